// File: rtl/lidar_scan_controller.sv
// LiDAR run/reset sequencer with a no-data watchdog, bounded restarts and a first-word-fall-through point FIFO.
// Optional build macro: LIDAR_ZERO_DIST_FILTER_EN (discard zero-distance points before the FIFO).
module lidar_scan_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned BACKOFF_CYCLES = 10_000_000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          enable_in,
  input  logic                          new_data_in,
  input  logic [31:0]                   angle_distance_in,
  output logic                          run_protocol_out,
  output logic                          lidar_rst_out,
  output logic [31:0]                   point_data_out,
  output logic                          point_sof_out,
  output logic                          point_valid_out,
  input  logic                          point_ready_in,
  output logic [2:0]                    state_out,
  output logic [1:0]                    retry_count_out,
  output logic [15:0]                   drop_count_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          fault_out
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BO_W  = $clog2(BACKOFF_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LOAD     = WD_W'(TIMEOUT_CYCLES);
  localparam logic [BO_W-1:0]  BO_LOAD     = BO_W'(BACKOFF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    ARMED   = 3'd2,
    RUNNING = 3'd3,
    BACKOFF = 3'd4,
    FAULT   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [BO_W-1:0]  bo_q, bo_d;
  logic [1:0]       retry_q, retry_d;
  logic             sof_pending_q, sof_pending_d;
  logic [15:0]      last_angle_q, last_angle_d;
  logic [15:0]      drop_q, drop_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             run_q, run_d, lrst_q, lrst_d, fault_q, fault_d;
  logic [32:0]      mem_q [FIFO_DEPTH];
  logic [1:0]       rst_sync_q;
  logic             rst_n_s;

  logic        strobe_s, active_s, keep_s, sof_bit_s, empty_s, full_s;
  logic        pop_s, try_push_s, push_s, drop_s;
  logic [32:0] head_s;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_q[1];

  // A strobe arriving as enable falls is discarded entirely.
  assign strobe_s = new_data_in & enable_in;
  assign active_s = (state_q == ARMED) | (state_q == RUNNING);
`ifdef LIDAR_ZERO_DIST_FILTER_EN
  assign keep_s = (angle_distance_in[15:0] != 16'd0);
`else
  assign keep_s = 1'b1;
`endif
  assign sof_bit_s  = sof_pending_q | (angle_distance_in[31:16] < last_angle_q);
  assign empty_s    = (count_q == {CNT_W{1'b0}});
  assign full_s     = (count_q == CNT_FULL);
  assign pop_s      = ~empty_s & point_ready_in & enable_in;
  assign try_push_s = active_s & strobe_s & keep_s;
  assign push_s     = try_push_s & (~full_s | pop_s);
  assign drop_s     = try_push_s & ~push_s;

  // Datapath next state: angle tracking, sof bookkeeping, drop counter, FIFO pointers.
  always_comb begin
    last_angle_d = strobe_s ? angle_distance_in[31:16] : last_angle_q;
    if (drop_s && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
    // A sof-carrying point that never reaches the FIFO hands its sof to the next one.
    if (state_q == START) begin
      sof_pending_d = 1'b1;
    end else if (push_s) begin
      sof_pending_d = 1'b0;
    end else if (active_s && strobe_s && sof_bit_s) begin
      sof_pending_d = 1'b1;
    end else begin
      sof_pending_d = sof_pending_q;
    end
    if (!enable_in) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Sequencer next state, watchdog/backoff counters and registered control outputs.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    bo_d    = bo_q;
    retry_d = retry_q;
    if (!enable_in) begin
      state_d = IDLE;
      retry_d = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = START;
        end
        START: begin
          wd_d    = WD_LOAD;
          state_d = ARMED;
        end
        ARMED, RUNNING: begin
          if (new_data_in) begin
            wd_d = WD_LOAD;
            if (state_q == ARMED) begin
              state_d = RUNNING;
              retry_d = 2'd0;
            end else begin
              state_d = RUNNING;
            end
          end else if (wd_q <= WD_W'(1'b1)) begin
            wd_d = {WD_W{1'b0}};
            if (({1'b0, retry_q} + 3'd1) == RETRY_LIMIT) begin
              state_d = FAULT;
            end else begin
              retry_d = retry_q + 2'd1;
              bo_d    = BO_LOAD;
              state_d = BACKOFF;
            end
          end else begin
            wd_d = wd_q - WD_W'(1'b1);
          end
        end
        BACKOFF: begin
          if (bo_q <= BO_W'(1'b1)) begin
            state_d = START;
          end else begin
            bo_d = bo_q - BO_W'(1'b1);
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    run_d   = (state_d == ARMED) | (state_d == RUNNING);
    lrst_d  = (state_d == START);
    fault_d = (state_d == FAULT);
  end

  // State and counter registers.
  always_ff @(posedge clk_in or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q       <= IDLE;
      wd_q          <= {WD_W{1'b0}};
      bo_q          <= {BO_W{1'b0}};
      retry_q       <= 2'd0;
      sof_pending_q <= 1'b1;
      last_angle_q  <= 16'd0;
      drop_q        <= 16'd0;
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      run_q         <= 1'b0;
      lrst_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      bo_q          <= bo_d;
      retry_q       <= retry_d;
      sof_pending_q <= sof_pending_d;
      last_angle_q  <= last_angle_d;
      drop_q        <= drop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      run_q         <= run_d;
      lrst_q        <= lrst_d;
      fault_q       <= fault_d;
    end
  end

  // Point storage; contents are only observed through the occupancy-gated head.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {sof_bit_s, angle_distance_in};
    end
  end

  assign head_s           = mem_q[rd_ptr_q];
  assign point_valid_out  = ~empty_s;
  assign point_data_out   = empty_s ? 32'h0000_0000 : head_s[31:0];
  assign point_sof_out    = ~empty_s & head_s[32];
  assign run_protocol_out = run_q;
  assign lidar_rst_out    = lrst_q;
  assign fault_out        = fault_q;
  assign state_out        = state_q;
  assign retry_count_out  = retry_q;
  assign drop_count_out   = drop_q;
  assign fifo_count_out   = count_q;

endmodule

// File: tb/tb_lidar_scan_controller.sv
// Directed bench for lidar_scan_controller with a queue scoreboard for FIFO output points.
module tb_lidar_scan_controller;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n_in, enable_in, new_data_in, point_ready_in;
  logic [31:0] angle_distance_in;
  logic        run_protocol_out, lidar_rst_out, point_sof_out, point_valid_out, fault_out;
  logic [31:0] point_data_out;
  logic [2:0]  state_out;
  logic [1:0]  retry_count_out;
  logic [15:0] drop_count_out;
  logic [2:0]  fifo_count_out;

  lidar_scan_controller #(
    .TIMEOUT_CYCLES(100), .BACKOFF_CYCLES(20), .MAX_RETRIES(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n_in), .enable_in(enable_in), .new_data_in(new_data_in),
    .angle_distance_in(angle_distance_in), .run_protocol_out(run_protocol_out),
    .lidar_rst_out(lidar_rst_out), .point_data_out(point_data_out), .point_sof_out(point_sof_out),
    .point_valid_out(point_valid_out), .point_ready_in(point_ready_in), .state_out(state_out),
    .retry_count_out(retry_count_out), .drop_count_out(drop_count_out),
    .fifo_count_out(fifo_count_out), .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic        sof_pend_m;
  logic [15:0] last_ang_m;
  int          drops_m;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one strobe cycle; decide acceptance from the model, enqueue after the sampling edge.
  task automatic strobe(input logic [31:0] d);
    logic sof;
    bit   keep;
    bit   accept;
    new_data_in       = 1'b1;
    angle_distance_in = d;
    sof        = sof_pend_m | (d[31:16] < last_ang_m);
    last_ang_m = d[31:16];
    keep       = 1'b1;
`ifdef LIDAR_ZERO_DIST_FILTER_EN
    keep = (d[15:0] != 16'd0);
`endif
    accept = keep && ((exp_q.size() < DEPTH) || (point_ready_in && exp_q.size() > 0));
    if (accept) sof_pend_m = 1'b0;
    else if (sof) sof_pend_m = 1'b1;
    if (keep && !accept && drops_m < 65535) drops_m++;
    tick(1);
    new_data_in = 1'b0;
    if (accept) exp_q.push_back({sof, d});
  endtask

  task automatic start_run();
    enable_in = 1'b1;
    tick(1);
    chk("start_lrst_high", 48'(lidar_rst_out), 48'd1);
    chk("start_state", 48'(state_out), 48'd1);
    chk("start_run_low", 48'(run_protocol_out), 48'd0);
    tick(1);
    chk("armed_lrst_low", 48'(lidar_rst_out), 48'd0);
    chk("armed_run_high", 48'(run_protocol_out), 48'd1);
    chk("armed_state", 48'(state_out), 48'd2);
    sof_pend_m = 1'b1;
  endtask

  task automatic stop_run();
    point_ready_in = 1'b0;
    enable_in      = 1'b0;
    tick(1);
    exp_q.delete();
    chk("stop_state", 48'(state_out), 48'd0);
    chk("stop_retry", 48'(retry_count_out), 48'd0);
    chk("stop_count", 48'(fifo_count_out), 48'd0);
    chk("stop_drop_held", 48'(drop_count_out), 48'(drops_m));
  endtask

  // Scoreboard monitor: occupancy every cycle, head contents on every handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert (point_valid_out === (exp_q.size() != 0)) else begin
        errors++;
        $error("FAIL valid: observed %0b expected %0b", point_valid_out, exp_q.size() != 0);
      end
      checks++;
      assert (fifo_count_out === 3'(exp_q.size())) else begin
        errors++;
        $error("FAIL fifo_count: observed %0d expected %0d", fifo_count_out, exp_q.size());
      end
      if (point_valid_out && point_ready_in && exp_q.size() != 0) begin
        checks++;
        assert ({point_sof_out, point_data_out} === exp_q[0]) else begin
          errors++;
          $error("FAIL point: observed %0h expected %0h", {point_sof_out, point_data_out}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int n;
    int m;
    rst_n_in = 1'b0; enable_in = 1'b0; new_data_in = 1'b0; point_ready_in = 1'b0;
    angle_distance_in = 32'h0; sof_pend_m = 1'b1; last_ang_m = 16'd0; drops_m = 0;
    #12;
    chk("rst_state", 48'(state_out), 48'd0);
    chk("rst_run", 48'(run_protocol_out), 48'd0);
    chk("rst_lrst", 48'(lidar_rst_out), 48'd0);
    chk("rst_valid", 48'(point_valid_out), 48'd0);
    chk("rst_data", 48'(point_data_out), 48'd0);
    chk("rst_sof", 48'(point_sof_out), 48'd0);
    chk("rst_drop", 48'(drop_count_out), 48'd0);
    chk("rst_count", 48'(fifo_count_out), 48'd0);
    chk("rst_retry", 48'(retry_count_out), 48'd0);
    chk("rst_fault", 48'(fault_out), 48'd0);
    @(posedge clk); #1;
    rst_n_in = 1'b1;
    tick(3);
    chk("idle_after_rst", 48'(state_out), 48'd0);
    mon_en = 1'b1;

    // Startup
    start_run();
    strobe(32'h0100_0200);
    chk("run_state", 48'(state_out), 48'd3);
    chk("first_valid", 48'(point_valid_out), 48'd1);
    chk("first_data", 48'(point_data_out), 48'h0100_0200);
    chk("first_sof", 48'(point_sof_out), 48'd1);
    point_ready_in = 1'b1;
    tick(2);
    point_ready_in = 1'b0;
    chk("first_drained", 48'(point_valid_out), 48'd0);

    // Revolution wrap after a fresh start
    stop_run();
    start_run();
    strobe(32'h5000_0001);
    strobe(32'h5800_0002);
    strobe(32'h0010_0003);
    chk("wrap_head_sof", 48'(point_sof_out), 48'd1);
    point_ready_in = 1'b1;
    tick(4);
    point_ready_in = 1'b0;
    chk("wrap_drained", 48'(fifo_count_out), 48'd0);

    // Overflow, then push and pop together while full
    for (int i = 0; i < 6; i++) strobe({16'h6000 + 16'(i * 256), 16'h0100 + 16'(i)});
    chk("ovf_count", 48'(fifo_count_out), 48'd4);
    chk("ovf_drop", 48'(drop_count_out), 48'd2);
    chk("ovf_drop_model", 48'(drop_count_out), 48'(drops_m));
    point_ready_in = 1'b1;
    strobe(32'h7000_0777);
    point_ready_in = 1'b0;
    chk("full_pushpop_count", 48'(fifo_count_out), 48'd4);
    chk("full_pushpop_drop", 48'(drop_count_out), 48'd2);
    point_ready_in = 1'b1;
    tick(6);
    point_ready_in = 1'b0;
    chk("ovf_drained", 48'(fifo_count_out), 48'd0);

    // Watchdog, backoff, second timeout into FAULT
    stop_run();
    start_run();
    n = 0;
    while (state_out == 3'd2 && n < 300) begin tick(1); n++; end
    chk("wd1_cycles", 48'(n), 48'd100);
    chk("wd1_state_backoff", 48'(state_out), 48'd4);
    chk("wd1_retry", 48'(retry_count_out), 48'd1);
    m = 0;
    while (state_out == 3'd4 && m < 300) begin
      chk("backoff_run_low", 48'(run_protocol_out), 48'd0);
      tick(1);
      m++;
    end
    chk("backoff_cycles", 48'(m), 48'd20);
    chk("restart_state", 48'(state_out), 48'd1);
    chk("restart_lrst", 48'(lidar_rst_out), 48'd1);
    tick(1);
    chk("rearmed_state", 48'(state_out), 48'd2);
    chk("rearmed_lrst_low", 48'(lidar_rst_out), 48'd0);
    sof_pend_m = 1'b1;
    n = 0;
    while (state_out == 3'd2 && n < 300) begin tick(1); n++; end
    chk("wd2_cycles", 48'(n), 48'd100);
    chk("fault_state", 48'(state_out), 48'd5);
    chk("fault_out", 48'(fault_out), 48'd1);
    chk("fault_run_low", 48'(run_protocol_out), 48'd0);
    tick(5);
    chk("fault_sticky", 48'(state_out), 48'd5);
    stop_run();
    chk("fault_cleared", 48'(fault_out), 48'd0);

    // Asynchronous reset with points queued
    start_run();
    strobe(32'h0100_0011);
    strobe(32'h0200_0022);
    strobe(32'h0300_0033);
    chk("pre_rst_count", 48'(fifo_count_out), 48'd3);
    mon_en = 1'b0;
    #3;
    rst_n_in = 1'b0;
    #1;
    chk("arst_valid", 48'(point_valid_out), 48'd0);
    chk("arst_run", 48'(run_protocol_out), 48'd0);
    chk("arst_count", 48'(fifo_count_out), 48'd0);
    chk("arst_drop", 48'(drop_count_out), 48'd0);
    chk("arst_retry", 48'(retry_count_out), 48'd0);
    chk("arst_state", 48'(state_out), 48'd0);
    exp_q.delete();
    drops_m = 0; last_ang_m = 16'd0; sof_pend_m = 1'b1;
    enable_in = 1'b0;
    @(posedge clk); #1;
    rst_n_in = 1'b1;
    tick(3);
    mon_en = 1'b1;

`ifdef LIDAR_ZERO_DIST_FILTER_EN
    // Zero-distance filter
    start_run();
    strobe(32'h0020_0000);
    chk("flt_state", 48'(state_out), 48'd3);
    chk("flt_none_queued", 48'(fifo_count_out), 48'd0);
    strobe(32'h0010_0064);
    chk("flt_one_queued", 48'(fifo_count_out), 48'd1);
    chk("flt_sof", 48'(point_sof_out), 48'd1);
    chk("flt_data", 48'(point_data_out), 48'h0010_0064);
    tick(90);
    strobe(32'h0030_0000);
    tick(90);
    chk("flt_no_timeout", 48'(state_out), 48'd3);
    chk("flt_retry", 48'(retry_count_out), 48'd0);
    chk("flt_drop", 48'(drop_count_out), 48'd0);
    point_ready_in = 1'b1;
    tick(2);
    point_ready_in = 1'b0;
    chk("flt_drained", 48'(fifo_count_out), 48'd0);
    stop_run();
`endif

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
